// File: rtl/run_seq_fsm.sv
// Run-length sequencer FSM: IDLE -> RUN for run_len cycles -> DONE, with abort and optional pause.
// Define FSM_PAUSE_EN to add the pause port and PAUSE state (2'b11 is illegal otherwise).
module run_seq_fsm #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned AUTO_RESTART = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] run_len,
   input  logic             abort,
   input  logic             done_ack,
`ifdef FSM_PAUSE_EN
   input  logic             pause,
`endif
   output logic [1:0]       state_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             len_err
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StDone  = 2'b10,
      StPause = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             busy_q, done_q, len_err_q, len_err_d;
   logic             start_ok, start_bad;

   assign start_ok  = enable && (run_len != '0);
   assign start_bad = enable && (run_len == '0);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      len_d     = len_q;
      len_err_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (abort) begin
               count_d = '0;
            end else if (start_ok) begin
               state_d = StRun;
               len_d   = run_len;
               count_d = '0;
            end else if (start_bad) begin
               len_err_d = 1'b1;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               count_d = '0;
`ifdef FSM_PAUSE_EN
            end else if (pause) begin
               state_d = StPause;
`endif
            end else if (count_q == len_q - CntOne) begin
               state_d = StDone;
               count_d = count_q + CntOne;
            end else begin
               count_d = count_q + CntOne;
            end
         end
         StDone: begin
            if (abort) begin
               state_d = StIdle;
               count_d = '0;
            end else if (AUTO_RESTART != 0) begin
               // DONE is a single-cycle state here; it either relaunches or falls back to IDLE
               if (start_ok) begin
                  state_d = StRun;
                  len_d   = run_len;
                  count_d = '0;
               end else begin
                  state_d   = StIdle;
                  len_err_d = start_bad;
               end
            end else if (done_ack) begin
               state_d = StIdle;
            end
         end
`ifdef FSM_PAUSE_EN
         StPause: begin
            if (abort) begin
               state_d = StIdle;
               count_d = '0;
            end else if (!pause) begin
               state_d = StRun;
            end
         end
`endif
         default: begin
            state_d = StIdle;
            count_d = '0;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with state_out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         count_q   <= '0;
         len_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         len_q     <= len_d;
         busy_q    <= (state_d == StRun) || (state_d == StPause);
         done_q    <= (state_d == StDone);
         len_err_q <= len_err_d;
      end
   end

   assign state_out = state_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_run_seq_fsm.sv
// Directed bench for run_seq_fsm: three instances (ack-exit, auto-restart, 4-bit counter).
module tb_run_seq_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic       enable, abort, done_ack, pause;
   logic [7:0] run_len;
   logic [3:0] run_len4;

   logic [1:0] st_a, st_b, st_c;
   logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, lerr_a, lerr_b, lerr_c;
   logic [7:0] cnt_a, cnt_b;
   logic [3:0] cnt_c;

   int n_tests = 0;
   int n_fail  = 0;

   run_seq_fsm #(.CNT_W(8), .AUTO_RESTART(0)) dut_a (
      .clk(clk), .reset_n(rst_a), .enable(enable), .run_len(run_len), .abort(abort),
      .done_ack(done_ack),
`ifdef FSM_PAUSE_EN
      .pause(pause),
`endif
      .state_out(st_a), .busy(busy_a), .done(done_a), .count(cnt_a), .len_err(lerr_a)
   );

   run_seq_fsm #(.CNT_W(8), .AUTO_RESTART(1)) dut_b (
      .clk(clk), .reset_n(rst_b), .enable(enable), .run_len(run_len), .abort(abort),
      .done_ack(done_ack),
`ifdef FSM_PAUSE_EN
      .pause(pause),
`endif
      .state_out(st_b), .busy(busy_b), .done(done_b), .count(cnt_b), .len_err(lerr_b)
   );

   run_seq_fsm #(.CNT_W(4), .AUTO_RESTART(0)) dut_c (
      .clk(clk), .reset_n(rst_c), .enable(enable), .run_len(run_len4), .abort(abort),
      .done_ack(done_ack),
`ifdef FSM_PAUSE_EN
      .pause(pause),
`endif
      .state_out(st_c), .busy(busy_c), .done(done_c), .count(cnt_c), .len_err(lerr_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      enable = 1'b0; abort = 1'b0; done_ack = 1'b0; pause = 1'b0;
      run_len = 8'd0; run_len4 = 4'd0;
      #3;
      chk("rst_state", 32'(st_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_len_err", 32'(lerr_a), 32'd0);
      tick();
      rst_a = 1'b1;

      // run_len=5: five RUN cycles, count 0..4, then DONE with count 5
      enable = 1'b1; run_len = 8'd5;
      tick();
      chk("run5_start_state", 32'(st_a), 32'd1);
      chk("run5_start_busy", 32'(busy_a), 32'd1);
      chk("run5_start_count", 32'(cnt_a), 32'd0);
      enable = 1'b0; run_len = 8'd9; done_ack = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         done_ack = 1'b0;
         chk("run5_count", 32'(cnt_a), 32'(i));
         chk("run5_busy", 32'(busy_a), 32'd1);
      end
      tick();
      chk("run5_done_state", 32'(st_a), 32'd2);
      chk("run5_done_flag", 32'(done_a), 32'd1);
      chk("run5_done_busy", 32'(busy_a), 32'd0);
      chk("run5_done_count", 32'(cnt_a), 32'd5);
      tick();
      chk("run5_done_hold", 32'(st_a), 32'd2);
      chk("run5_done_hold_cnt", 32'(cnt_a), 32'd5);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      chk("run5_ack_idle", 32'(st_a), 32'd0);
      chk("run5_ack_done", 32'(done_a), 32'd0);

      // run_len=0 held two cycles: len_err each cycle, stay IDLE
      enable = 1'b1; run_len = 8'd0;
      tick();
      chk("len0_state1", 32'(st_a), 32'd0);
      chk("len0_err1", 32'(lerr_a), 32'd1);
      tick();
      chk("len0_state2", 32'(st_a), 32'd0);
      chk("len0_err2", 32'(lerr_a), 32'd1);
      enable = 1'b0;
      tick();
      chk("len0_err_clear", 32'(lerr_a), 32'd0);

      // run_len=1: a single RUN cycle
      enable = 1'b1; run_len = 8'd1;
      tick();
      enable = 1'b0;
      chk("len1_run", 32'(st_a), 32'd1);
      tick();
      chk("len1_done", 32'(st_a), 32'd2);
      chk("len1_count", 32'(cnt_a), 32'd1);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      chk("len1_idle", 32'(st_a), 32'd0);

      // abort (with pause) at count=3
      enable = 1'b1; run_len = 8'd10;
      tick();
      enable = 1'b0;
      repeat (3) tick();
      chk("abort_pre_count", 32'(cnt_a), 32'd3);
      abort = 1'b1; pause = 1'b1;
      tick();
      abort = 1'b0; pause = 1'b0;
      chk("abort_state", 32'(st_a), 32'd0);
      chk("abort_count", 32'(cnt_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);

`ifdef FSM_PAUSE_EN
      enable = 1'b1; run_len = 8'd4;
      tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("pause_pre_count", 32'(cnt_a), 32'd2);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_state", 32'(st_a), 32'd3);
         chk("pause_count", 32'(cnt_a), 32'd2);
         chk("pause_busy", 32'(busy_a), 32'd1);
      end
      pause = 1'b0;
      tick();
      chk("resume_state", 32'(st_a), 32'd1);
      chk("resume_count", 32'(cnt_a), 32'd2);
      tick();
      chk("resume_count2", 32'(cnt_a), 32'd3);
      tick();
      chk("pause_done_state", 32'(st_a), 32'd2);
      chk("pause_done_count", 32'(cnt_a), 32'd4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("pause_abort_idle", 32'(st_a), 32'd0);
`endif

      // abort beats done_ack in DONE and clears count
      enable = 1'b1; run_len = 8'd2;
      tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("dabort_pre_state", 32'(st_a), 32'd2);
      abort = 1'b1; done_ack = 1'b1;
      tick();
      abort = 1'b0; done_ack = 1'b0;
      chk("dabort_state", 32'(st_a), 32'd0);
      chk("dabort_count", 32'(cnt_a), 32'd0);

      // auto-restart instance: RUN, RUN, DONE repeating
      rst_a = 1'b0; rst_b = 1'b1;
      enable = 1'b1; run_len = 8'd2;
      for (int p = 0; p < 2; p++) begin
         tick();
         chk("ar_run0_state", 32'(st_b), 32'd1);
         chk("ar_run0_done", 32'(done_b), 32'd0);
         chk("ar_run0_count", 32'(cnt_b), 32'd0);
         tick();
         chk("ar_run1_count", 32'(cnt_b), 32'd1);
         chk("ar_run1_done", 32'(done_b), 32'd0);
         tick();
         chk("ar_done_state", 32'(st_b), 32'd2);
         chk("ar_done_flag", 32'(done_b), 32'd1);
         chk("ar_done_count", 32'(cnt_b), 32'd2);
      end
      enable = 1'b0;
      tick();
      chk("ar_exit_state", 32'(st_b), 32'd0);
      chk("ar_exit_done", 32'(done_b), 32'd0);
      enable = 1'b1; run_len = 8'd2;
      tick();
      run_len = 8'd0;
      tick();
      chk("ar_len_latched", 32'(st_b), 32'd1);
      tick();
      chk("ar_done2_state", 32'(st_b), 32'd2);
      tick();
      chk("ar_len0_state", 32'(st_b), 32'd0);
      chk("ar_len0_err", 32'(lerr_b), 32'd1);
      enable = 1'b0;
      tick();
      chk("ar_len0_err_clr", 32'(lerr_b), 32'd0);

      // 4-bit instance: asynchronous reset mid-RUN, then all-ones run without wrap
      rst_b = 1'b0; rst_c = 1'b1;
      enable = 1'b1; run_len4 = 4'd15;
      tick();
      enable = 1'b0;
      chk("c_start_state", 32'(st_c), 32'd1);
      repeat (7) tick();
      chk("c_pre_rst_count", 32'(cnt_c), 32'd7);
      #2;
      rst_c = 1'b0;
      #1;
      chk("c_async_state", 32'(st_c), 32'd0);
      chk("c_async_count", 32'(cnt_c), 32'd0);
      chk("c_async_busy", 32'(busy_c), 32'd0);
      chk("c_async_done", 32'(done_c), 32'd0);
      @(negedge clk);
      rst_c = 1'b1;
      enable = 1'b1; run_len4 = 4'd15;
      tick();
      enable = 1'b0;
      chk("c_full_start", 32'(cnt_c), 32'd0);
      repeat (14) tick();
      chk("c_full_last_run", 32'(cnt_c), 32'd14);
      chk("c_full_last_state", 32'(st_c), 32'd1);
      tick();
      chk("c_full_done_state", 32'(st_c), 32'd2);
      chk("c_full_done_count", 32'(cnt_c), 32'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
